aes_key_schedule_seq: RTL and testbench

//  Iterative AES key expander feeding the AESDecrypt datapath. Accepts a cipher key
//  (128/192/256 b), generates one 32-bit schedule word per clock, and stores all NR+1

---
 rtl/aes_pkg.sv | 49 ++++
 rtl/aes_key_schedule_seq_if.sv | 22 ++
 rtl/aes_subword.sv | 17 +
 rtl/aes_key_schedule_seq.sv | 116 +++++++++++
 tb/tb_aes_key_schedule_seq.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule slice.
// Contents: forward S-box, Rcon table, key-length pairs, word typedef, FSM states.
package aes_pkg;

  localparam int unsigned NK_128 = 4;
  localparam int unsigned NR_128 = 10;
  localparam int unsigned NK_192 = 6;
  localparam int unsigned NR_192 = 12;
  localparam int unsigned NK_256 = 8;
  localparam int unsigned NR_256 = 14;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_EXPAND,
    KS_DONE
  } ks_state_e;

  // Index 0 is never used; Rcon[1..10] follow.
  localparam logic [7:0] RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_key_schedule_seq_if.sv
// Key-load and round-key read bus of the key scheduler.
interface aes_key_schedule_seq_if #(
  parameter int unsigned NK = 4
) ();
  logic              key_valid;
  logic              key_ready;
  logic [NK*32-1:0]  key_in;
  logic              busy;
  logic              done;
  logic [3:0]        rk_addr;
  logic [127:0]      rk_out;

  modport master (
    output key_valid, key_in, rk_addr,
    input  key_ready, busy, done, rk_out
  );

  modport slave (
    input  key_valid, key_in, rk_addr,
    output key_ready, busy, done, rk_out
  );
endinterface

// File: rtl/aes_subword.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  word_t word_i,
  output word_t word_o
);

  // Byte-wise S-box substitution
  always_comb begin
    word_o = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      word_o[8*b +: 8] = sub_byte(word_i[8*b +: 8]);
    end
  end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES key expander: one schedule word per clock into an NW x 32 register
// file, with a registered round-key read port.
// Optional macro AES_KS_REVERSE_ADDR_EN: rk_addr is a decrypt round index (NR-rk_addr).
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int unsigned NK = 4,
  parameter int unsigned NR = 10
) (
  input logic                   clk,
  input logic                   rst_n,
  aes_key_schedule_seq_if.slave bus
);

  localparam int unsigned NW = 4 * (NR + 1);
  localparam int unsigned CW = $clog2(NW);

  ks_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    mod_q;
  logic [3:0]    rci_q;
  word_t         w_q [NW];

  logic          key_ready;
  logic          accept;
  logic          last_word;
  word_t         prev_w, old_w, sub_in, sub_out, tmp_w, new_w;
  logic [3:0]    rk_sel;
  state_t        rk_d, rk_q;

  assign key_ready     = (state_q != KS_EXPAND);
  assign accept        = bus.key_valid && key_ready;
  assign last_word     = (cnt_q == CW'(NW - 1));
  assign bus.key_ready = key_ready;
  assign bus.busy      = (state_q == KS_EXPAND);
  assign bus.done      = (state_q == KS_DONE);
  assign bus.rk_out    = rk_q;

  aes_subword u_subword (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= KS_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      KS_IDLE, KS_DONE: if (accept) state_d = KS_EXPAND;
      KS_EXPAND:        if (last_word) state_d = KS_DONE;
      default:          state_d = KS_IDLE;
    endcase
  end

  // Next schedule word; mod_q tracks i%NK and rci_q tracks i/NK so no divider is needed
  always_comb begin
    prev_w = w_q[cnt_q - CW'(1)];
    old_w  = w_q[cnt_q - CW'(NK)];
    sub_in = (mod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    if (mod_q == 3'd0)                 tmp_w = sub_out ^ {RCON[rci_q], 24'h0};
    else if (NK == 8 && mod_q == 3'd4) tmp_w = sub_out;
    else                               tmp_w = prev_w;
    new_w = old_w ^ tmp_w;
  end

  // Key load, word generation and i%NK / i/NK tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NW; k++) w_q[k] <= '0;
      cnt_q <= '0;
      mod_q <= '0;
      rci_q <= '0;
    end else if (accept) begin
      for (int unsigned k = 0; k < NK; k++) w_q[k] <= bus.key_in[(NK-k)*32-1 -: 32];
      cnt_q <= CW'(NK);
      mod_q <= '0;
      rci_q <= 4'd1;
    end else if (state_q == KS_EXPAND) begin
      w_q[cnt_q] <= new_w;
      cnt_q      <= cnt_q + CW'(1);
      if (mod_q == 3'(NK - 1)) begin
        mod_q <= '0;
        rci_q <= rci_q + 4'd1;
      end else begin
        mod_q <= mod_q + 3'd1;
      end
    end
  end

  // Round-key read mux; zero unless the schedule is complete and the index is valid
  always_comb begin
`ifdef AES_KS_REVERSE_ADDR_EN
    rk_sel = 4'(NR) - bus.rk_addr;
`else
    rk_sel = bus.rk_addr;
`endif
    rk_d = '0;
    if (state_q == KS_DONE && bus.rk_addr <= 4'(NR)) begin
      for (int unsigned j = 0; j < 4; j++) begin
        rk_d[127-32*j -: 32] = w_q[CW'({rk_sel, 2'(j)})];
      end
    end
  end

  // Registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rk_q <= '0;
    else        rk_q <= rk_d;
  end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Bench for aes_key_schedule_seq: AES-128/192/256 instances side by side, checked each
// cycle against a behavioural key-expansion model whose S-box is derived from GF(2^8).
module tb_aes_key_schedule_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KFIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  int NKS [3] = '{4, 6, 8};
  int NRS [3] = '{10, 12, 14};
  string NM [3] = '{"k128", "k192", "k256"};

  logic         kv  [3];
  logic [255:0] kin [3];
  logic [3:0]   ra  [3];
  logic         rdy [3];
  logic         bsy [3];
  logic         dn  [3];
  logic [127:0] rko [3];

  aes_key_schedule_seq_if #(.NK(4)) if128 ();
  aes_key_schedule_seq_if #(.NK(6)) if192 ();
  aes_key_schedule_seq_if #(.NK(8)) if256 ();

  assign if128.key_valid = kv[0];
  assign if128.key_in    = kin[0][255 -: 128];
  assign if128.rk_addr   = ra[0];
  assign if192.key_valid = kv[1];
  assign if192.key_in    = kin[1][255 -: 192];
  assign if192.rk_addr   = ra[1];
  assign if256.key_valid = kv[2];
  assign if256.key_in    = kin[2];
  assign if256.rk_addr   = ra[2];

  assign rdy[0] = if128.key_ready; assign bsy[0] = if128.busy;
  assign dn[0]  = if128.done;      assign rko[0] = if128.rk_out;
  assign rdy[1] = if192.key_ready; assign bsy[1] = if192.busy;
  assign dn[1]  = if192.done;      assign rko[1] = if192.rk_out;
  assign rdy[2] = if256.key_ready; assign bsy[2] = if256.busy;
  assign dn[2]  = if256.done;      assign rko[2] = if256.rk_out;

  aes_key_schedule_seq #(.NK(4), .NR(10)) dut128 (.clk(clk), .rst_n(rst_n), .bus(if128.slave));
  aes_key_schedule_seq #(.NK(6), .NR(12)) dut192 (.clk(clk), .rst_n(rst_n), .bus(if192.slave));
  aes_key_schedule_seq #(.NK(8), .NR(14)) dut256 (.clk(clk), .rst_n(rst_n), .bus(if256.slave));

  int n_assert = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Full FIPS-197 expansion; key left-aligned in 256 bits
  function automatic logic [14:0][127:0] expand(input int nk, input int nr, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [14:0][127:0] r;
    r = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]});
        rc = 8'h01;
        for (int j = 1; j < i/nk; j++) rc = xt(rc);
        t[31:24] = t[31:24] ^ rc;
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int k = 0; k <= nr; k++) r[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return r;
  endfunction

  function automatic logic [3:0] lit(input int nr, input int r);
`ifdef AES_KS_REVERSE_ADDR_EN
    return 4'(nr - r);
`else
    return 4'(r);
`endif
  endfunction

  // ---------------- behavioural model ----------------
  int                 m_cnt  [3];
  logic               m_have [3];
  logic [127:0]       m_rk   [3];
  logic [14:0][127:0] m_keys [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i]  <= 0;
        m_have[i] <= 1'b0;
        m_rk[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_have[i] && int'(ra[i]) <= NRS[i])
          m_rk[i] <= m_keys[i][lit(NRS[i], int'(ra[i]))];
        else
          m_rk[i] <= '0;
        if (kv[i] && m_cnt[i] == 0) begin
          m_keys[i] <= expand(NKS[i], NRS[i], kin[i]);
          m_cnt[i]  <= 4*(NRS[i]+1) - NKS[i];
          m_have[i] <= 1'b0;
        end else if (m_cnt[i] > 0) begin
          m_cnt[i] <= m_cnt[i] - 1;
          if (m_cnt[i] == 1) m_have[i] <= 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk({NM[i], ".key_ready"}, 128'(rdy[i]), 128'(m_cnt[i] == 0));
        chk({NM[i], ".busy"},      128'(bsy[i]), 128'(m_cnt[i] != 0));
        chk({NM[i], ".done"},      128'(dn[i]),  128'(m_have[i]));
        chk({NM[i], ".rk_out"},    rko[i],       m_rk[i]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  int first_done [3];
  int c;

  initial begin
    logic [14:0][127:0] pin;
    for (int i = 0; i < 3; i++) begin
      kv[i] = 1'b0; kin[i] = '0; ra[i] = '0;
    end
    build_sbox();
    chk("pin.sbox00", 128'(sb[8'h00]), 128'h63);
    chk("pin.sbox53", 128'(sb[8'h53]), 128'hed);
    pin = expand(4, 10, {K128, 128'h0});
    chk("pin.model128_r10", pin[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    pin = expand(8, 14, K256);
    chk("pin.model256_r14", pin[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // Reset values
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk({NM[i], ".rst_ready"}, 128'(rdy[i]), 128'h1);
      chk({NM[i], ".rst_busy"},  128'(bsy[i]), 128'h0);
      chk({NM[i], ".rst_done"},  128'(dn[i]),  128'h0);
      chk({NM[i], ".rst_rk"},    rko[i],       128'h0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Load all three keys; instance 0 keeps key_valid high with another key while busy
    kin[0] = {K128, 128'h0};
    kin[1] = {K192, 64'h0};
    kin[2] = K256;
    for (int i = 0; i < 3; i++) begin
      kv[i] = 1'b1; first_done[i] = -1;
    end
    @(posedge clk); #1;
    kv[1] = 1'b0; kv[2] = 1'b0;
    kin[0] = {128'hffeeddccbbaa99887766554433221100, 128'h0};
    for (c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 4) kv[0] = 1'b0;
      if (c == 2) begin
        chk("k128.ready_while_busy", 128'(rdy[0]), 128'h0);
        chk("k128.read_before_done", rko[0], 128'h0);
      end
      for (int i = 0; i < 3; i++) if (dn[i] && first_done[i] < 0) first_done[i] = c;
    end
    chk("k128.latency", 128'(first_done[0]), 128'd40);
    chk("k192.latency", 128'(first_done[1]), 128'd46);
    chk("k256.latency", 128'(first_done[2]), 128'd52);

    // Final round keys
    ra[0] = lit(10, 10); ra[1] = lit(12, 12); ra[2] = lit(14, 14);
    @(posedge clk); #1;
    chk("k128.rk10", rko[0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("k192.rk12", rko[1], 128'ha4970a331a78dc09c418c271e3a41d5d);
    chk("k256.rk14", rko[2], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    ra[0] = lit(10, 0);
    @(posedge clk); #1;
    chk("k128.rk0", rko[0], K128);
    for (int i = 0; i < 3; i++) ra[i] = 4'd15;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) chk({NM[i], ".addr15"}, rko[i], 128'h0);

    // Re-key from DONE: done drops on the accept edge
    kin[0] = {KFIPS, 128'h0};
    kv[0] = 1'b1;
    ra[0] = lit(10, 10);
    @(posedge clk); #1;
    kv[0] = 1'b0;
    chk("k128.rekey_done_drop", 128'(dn[0]), 128'h0);
    chk("k128.rekey_busy", 128'(bsy[0]), 128'h1);
    repeat (40) @(posedge clk);
    #1 chk("k128.rekey_done", 128'(dn[0]), 128'h1);
    @(posedge clk); #1;
    chk("k128.fips_rk10", rko[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    ra[0] = lit(10, 0);
    @(posedge clk); #1;
    chk("k128.fips_rk0", rko[0], KFIPS);

    // Reset in the middle of an expansion
    kin[0] = {K128, 128'h0};
    kv[0] = 1'b1;
    @(posedge clk); #1;
    kv[0] = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk({NM[i], ".midrst_ready"}, 128'(rdy[i]), 128'h1);
      chk({NM[i], ".midrst_busy"},  128'(bsy[i]), 128'h0);
      chk({NM[i], ".midrst_done"},  128'(dn[i]),  128'h0);
      chk({NM[i], ".midrst_rk"},    rko[i],       128'h0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fresh key after the abort
    kin[0] = {KFIPS, 128'h0};
    kv[0] = 1'b1;
    ra[0] = lit(10, 10);
    @(posedge clk); #1;
    kv[0] = 1'b0;
    first_done[0] = -1;
    for (c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (dn[0]) begin
        first_done[0] = c;
        break;
      end
    end
    chk("k128.post_rst_latency", 128'(first_done[0]), 128'd40);
    @(posedge clk); #1;
    chk("k128.post_rst_rk10", rko[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
